// File: rtl/cpu_pkg.sv
// Shared types and field layout for the 12-bit instruction set of the
// 8x4-bit register-file microprocessor.
package cpu_pkg;
    localparam int INSTR_W = 12;
    localparam int DATA_W  = 4;
    localparam int RADDR_W = 3;

    localparam int OP_MSB  = 11;
    localparam int OP_LSB  = 9;
    localparam int WA_MSB  = 8;
    localparam int WA_LSB  = 6;
    localparam int AD1_MSB = 5;
    localparam int AD1_LSB = 3;
    localparam int AD2_MSB = 2;
    localparam int AD2_LSB = 0;
    localparam int IMM_MSB = 3;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_MOV  = 3'b100,
        OP_LDI  = 3'b101,
        OP_JMP  = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALTED    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = S_IDLE,
        ST_FETCH     = S_FETCH,
        ST_DECODE    = S_DECODE,
        ST_EXECUTE   = S_EXECUTE,
        ST_WRITEBACK = S_WRITEBACK,
        ST_HALTED    = S_HALTED
    } state_t;

    function automatic logic op_writes_rf(opcode_t op);
        return (op != OP_JMP) && (op != OP_HALT);
    endfunction
endpackage

// File: rtl/control_unit_if.sv
// Bundle between the sequencer and its datapath: instruction ROM,
// register-file ports and ALU select/result.
interface control_unit_if import cpu_pkg::*; #(parameter int PC_W = 4);
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [RADDR_W-1:0] RF_ad1;
    logic [RADDR_W-1:0] RF_ad2;
    logic [DATA_W-1:0]  RF_d1;
    logic [DATA_W-1:0]  RF_d2;
    logic [RADDR_W-1:0] RF_wa;
    logic               RF_we;
    logic [DATA_W-1:0]  RF_wd;
    logic [1:0]         alu_op;
    logic [DATA_W-1:0]  alu_result;

    modport master (
        output imem_addr, RF_ad1, RF_ad2, RF_wa, RF_we, RF_wd, alu_op,
        input  imem_data, RF_d1, RF_d2, alu_result
    );

    modport slave (
        input  imem_addr, RF_ad1, RF_ad2, RF_wa, RF_we, RF_wd, alu_op,
        output imem_data, RF_d1, RF_d2, alu_result
    );
endinterface

// File: rtl/instr_decoder.sv
// Purely combinational split of the instruction register into its fields.
module instr_decoder import cpu_pkg::*; #(
    parameter int PC_W = 4
) (
    input  logic [INSTR_W-1:0] ir,
    output opcode_t            opcode,
    output logic [RADDR_W-1:0] wa,
    output logic [RADDR_W-1:0] ad1,
    output logic [RADDR_W-1:0] ad2,
    output logic [DATA_W-1:0]  imm,
    output logic [PC_W-1:0]    target,
    output logic               is_alu,
    output logic               writes_rf
);
    assign opcode    = opcode_t'(ir[OP_MSB:OP_LSB]);
    assign wa        = ir[WA_MSB:WA_LSB];
    assign ad1       = ir[AD1_MSB:AD1_LSB];
    assign ad2       = ir[AD2_MSB:AD2_LSB];
    assign imm       = ir[IMM_MSB:0];
    assign target    = ir[PC_W-1:0];
    assign is_alu    = ~ir[OP_MSB];
    assign writes_rf = op_writes_rf(opcode);
endmodule

// File: rtl/control_unit.sv
// FETCH-DECODE-EXECUTE-WRITEBACK sequencer; owns pc, ir, result and the
// start/done handshake.
module control_unit import cpu_pkg::*; #(
    parameter int PC_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    control_unit_if.master bus
);
    state_t             state_reg, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [INSTR_W-1:0] ir_reg, ir_next;
    logic [DATA_W-1:0]  result_reg, result_next;

    opcode_t            opcode;
    logic [RADDR_W-1:0] wa, ad1, ad2;
    logic [DATA_W-1:0]  imm;
    logic [PC_W-1:0]    target;
    logic               is_alu, writes_rf;
    logic               in_flight, in_wb;

    instr_decoder #(.PC_W(PC_W)) u_decoder (
        .ir        (ir_reg),
        .opcode    (opcode),
        .wa        (wa),
        .ad1       (ad1),
        .ad2       (ad2),
        .imm       (imm),
        .target    (target),
        .is_alu    (is_alu),
        .writes_rf (writes_rf)
    );

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        ir_next     = ir_reg;
        result_next = result_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                ir_next    = bus.imem_data;
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                state_next = (opcode == OP_HALT) ? ST_HALTED : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (is_alu)                result_next = bus.alu_result;
                else if (opcode == OP_MOV) result_next = bus.RF_d1;
                else if (opcode == OP_LDI) result_next = imm;
                if (opcode == OP_JMP) pc_next = target;
                state_next = writes_rf ? ST_WRITEBACK : ST_FETCH;
            end
            ST_WRITEBACK: begin
                pc_next    = pc_reg + 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALTED: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= '0;
            ir_reg     <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            ir_reg     <= ir_next;
            result_reg <= result_next;
        end
    end

    assign in_flight = (state_reg == ST_DECODE) || (state_reg == ST_EXECUTE) ||
                       (state_reg == ST_WRITEBACK);
    assign in_wb     = (state_reg == ST_WRITEBACK);

    assign bus.imem_addr = pc_reg;
    assign bus.RF_ad1    = in_flight ? ad1 : '0;
    assign bus.RF_ad2    = in_flight ? ad2 : '0;
    assign bus.alu_op    = (in_flight && is_alu) ? ir_reg[OP_LSB+1:OP_LSB] : 2'b00;
    // Reset in the writeback cycle must suppress the write landing on that same edge.
    assign bus.RF_we     = in_wb && !rst;
    assign bus.RF_wa     = in_wb ? wa : '0;
    assign bus.RF_wd     = in_wb ? result_reg : '0;

    assign busy = (state_reg == ST_FETCH) || in_flight;
    assign done = (state_reg == ST_HALTED);
endmodule
